// File: rtl/ps2_input_mapper.sv
// PS/2 + joystick input front-end: programmable keymap, 0/90/180/270 rotation, coin pulse.
// Defining AUTOFIRE_EN adds the af_mask port and a post-rotation autofire stage.
module ps2_input_mapper #(
  parameter int unsigned NUM_BTN    = 8,
  parameter int unsigned COIN_PULSE = 600000,
  parameter int unsigned AF_DIV     = 200000
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic [10:0]                ps2_key,
  input  logic [NUM_BTN-1:0]         joy_in,
  input  logic [1:0]                 rotate,
  input  logic                       map_we,
  input  logic [$clog2(NUM_BTN)-1:0] map_addr,
  input  logic [8:0]                 map_code,
`ifdef AUTOFIRE_EN
  input  logic [NUM_BTN-1:0]         af_mask,
`endif
  output logic [NUM_BTN-1:0]         btn_out,
  output logic                       coin_out
);

  localparam int unsigned CW = $clog2(COIN_PULSE + 1);
  localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_PULSE - 1);

  if (NUM_BTN < 8) begin : g_bad_num_btn
    $error("ps2_input_mapper: NUM_BTN must be at least 8");
  end
  if (COIN_PULSE < 1 || AF_DIV < 1) begin : g_bad_timing
    $error("ps2_input_mapper: COIN_PULSE and AF_DIV must be at least 1");
  end

  typedef enum logic [1:0] {
    COIN_IDLE,
    COIN_PULSE_ST,
    COIN_HOLD
  } coin_state_e;

  function automatic logic [8:0] default_code(input int unsigned slot);
    case (slot)
      0:       return 9'h175;
      1:       return 9'h172;
      2:       return 9'h16B;
      3:       return 9'h174;
      4:       return 9'h014;
      5:       return 9'h029;
      6:       return 9'h005;
      7:       return 9'h006;
      default: return 9'h000;
    endcase
  endfunction

  logic [8:0]         keymap_q [NUM_BTN];
  logic [8:0]         keymap_d [NUM_BTN];
  logic [NUM_BTN-1:0] key_state_q, key_state_d;
  logic               prev_tog_q, armed_q;
  logic               key_event;
  logic               map_ok;
  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] rot_raw;
  logic [NUM_BTN-1:0] btn_q, btn_d;

  coin_state_e        coin_state_q, coin_state_d;
  logic [CW-1:0]      coin_cnt_q, coin_cnt_d;
  logic               coin_q, coin_d;
  logic               start_prev_q, start_now, start_rise;

  assign key_event = armed_q && (ps2_key[10] != prev_tog_q);
  assign map_ok    = map_we && (32'(map_addr) < NUM_BTN);

  // Event matching uses the pre-write codes; the write then overrides that slot's state.
  always_comb begin
    keymap_d    = keymap_q;
    key_state_d = key_state_q;
    if (key_event) begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        if (keymap_q[i] != 9'h000 && keymap_q[i] == ps2_key[8:0]) begin
          key_state_d[i] = ps2_key[9];
        end
      end
    end
    if (map_ok) begin
      keymap_d[map_addr]    = map_code;
      key_state_d[map_addr] = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        keymap_q[i] <= default_code(i);
      end
      key_state_q <= '0;
      prev_tog_q  <= 1'b0;
      armed_q     <= 1'b0;
      btn_q       <= '0;
    end else begin
      keymap_q    <= keymap_d;
      key_state_q <= key_state_d;
      prev_tog_q  <= ps2_key[10];
      armed_q     <= 1'b1;
      btn_q       <= btn_d;
    end
  end

  assign raw = key_state_q | joy_in;

  always_comb begin
    rot_raw = raw;
    case (rotate)
      2'd1:    rot_raw[3:0] = {raw[0], raw[1], raw[3], raw[2]};
      2'd2:    rot_raw[3:0] = {raw[2], raw[3], raw[0], raw[1]};
      2'd3:    rot_raw[3:0] = {raw[1], raw[0], raw[2], raw[3]};
      default: rot_raw[3:0] = raw[3:0];
    endcase
  end

`ifdef AUTOFIRE_EN
  localparam int unsigned FW = $clog2(AF_DIV + 1);

  logic [FW-1:0]      af_cnt_q, af_cnt_d;
  logic               af_phase_q, af_phase_d;
  logic [NUM_BTN-1:0] rot_prev_q;
  logic               af_rise;

  // Output follows the updated phase so a fresh masked press is high on its first cycle.
  always_comb begin
    af_rise    = |(af_mask & rot_raw & ~rot_prev_q);
    af_cnt_d   = af_cnt_q + FW'(1);
    af_phase_d = af_phase_q;
    if (af_rise) begin
      af_cnt_d   = '0;
      af_phase_d = 1'b1;
    end else if (af_cnt_q == FW'(AF_DIV - 1)) begin
      af_cnt_d   = '0;
      af_phase_d = ~af_phase_q;
    end
    btn_d = (rot_raw & ~af_mask) | (rot_raw & af_mask & {NUM_BTN{af_phase_d}});
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt_q   <= '0;
      af_phase_q <= 1'b0;
      rot_prev_q <= '0;
    end else begin
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
      rot_prev_q <= rot_raw;
    end
  end
`else
  always_comb begin
    btn_d = rot_raw;
  end
`endif

  assign start_now  = raw[6] | raw[7];
  assign start_rise = start_now & ~start_prev_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      coin_state_q <= COIN_IDLE;
      coin_cnt_q   <= '0;
      coin_q       <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      coin_state_q <= coin_state_d;
      coin_cnt_q   <= coin_cnt_d;
      coin_q       <= coin_d;
      start_prev_q <= start_now;
    end
  end

  always_comb begin
    coin_state_d = coin_state_q;
    coin_cnt_d   = coin_cnt_q;
    case (coin_state_q)
      COIN_IDLE: begin
        if (start_rise) begin
          coin_state_d = COIN_PULSE_ST;
          coin_cnt_d   = COIN_LOAD;
        end
      end
      COIN_PULSE_ST: begin
        if (coin_cnt_q == '0) begin
          coin_state_d = COIN_HOLD;
        end else begin
          coin_cnt_d = coin_cnt_q - CW'(1);
        end
      end
      COIN_HOLD: begin
        if (!start_now) begin
          coin_state_d = COIN_IDLE;
        end
      end
      default: coin_state_d = COIN_IDLE;
    endcase
  end

  always_comb begin
    coin_d = 1'b0;
    case (coin_state_q)
      COIN_IDLE:     coin_d = start_rise;
      COIN_PULSE_ST: coin_d = (coin_cnt_q != '0);
      default:       coin_d = 1'b0;
    endcase
  end

  assign btn_out  = btn_q;
  assign coin_out = coin_q;

endmodule

// File: tb/tb_ps2_input_mapper.sv
// Bench for ps2_input_mapper: directed steps followed by randomized traffic vs a behavioural model.
module tb_ps2_input_mapper;
  localparam int NB = 8;
  localparam int CP = 16;
  localparam int AD = 4;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic [10:0]   ps2_key;
  logic [NB-1:0] joy_in;
  logic [1:0]    rotate;
  logic          map_we;
  logic [2:0]    map_addr;
  logic [8:0]    map_code;
  logic [NB-1:0] af_mask;
  logic [NB-1:0] btn_out;
  logic          coin_out;

  ps2_input_mapper #(.NUM_BTN(NB), .COIN_PULSE(CP), .AF_DIV(AD)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ps2_key (ps2_key),
    .joy_in  (joy_in),
    .rotate  (rotate),
    .map_we  (map_we),
    .map_addr(map_addr),
    .map_code(map_code),
`ifdef AUTOFIRE_EN
    .af_mask (af_mask),
`endif
    .btn_out (btn_out),
    .coin_out(coin_out)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  logic [8:0] map_m [NB];
  logic [7:0] key_m;
  logic [7:0] btn_m;
  bit         armed_m, prev_tog_m, coin_m, coin_wait, start_prev_m, chk_btn;
  int         coin_rem;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Directions as compass angles; rotating by N quarter turns pulls each output from angle-90*N.
  function automatic logic [7:0] rot_model(input logic [7:0] r, input logic [1:0] rt);
    int ang [4];
    logic [7:0] o;
    ang = '{0, 180, 270, 90};
    o = r;
    for (int d = 0; d < 4; d++)
      for (int s = 0; s < 4; s++)
        if (ang[s] == (ang[d] + 360 - 90 * int'(rt)) % 360) o[d] = r[s];
    return o;
  endfunction

  task automatic model_reset();
    map_m = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h014, 9'h029, 9'h005, 9'h006};
    key_m = '0; btn_m = '0; armed_m = 0; prev_tog_m = 0;
    coin_m = 0; coin_rem = 0; coin_wait = 0; start_prev_m = 0;
  endtask

  task automatic model_edge();
    logic [7:0] raw;
    logic [7:0] kn;
    bit st;
    raw = key_m | joy_in;
    kn  = key_m;
    st  = raw[6] | raw[7];
    btn_m = rot_model(raw, rotate);
    if (coin_rem > 0) begin
      coin_rem--;
      if (coin_rem == 0) coin_wait = 1;
    end else if (coin_wait) begin
      if (!st) coin_wait = 0;
    end else if (st && !start_prev_m) begin
      coin_rem = CP;
    end
    start_prev_m = st;
    coin_m = (coin_rem > 0);
    if (armed_m && ps2_key[10] != prev_tog_m)
      for (int s = 0; s < NB; s++)
        if (map_m[s] != 9'h000 && map_m[s] == ps2_key[8:0]) kn[s] = ps2_key[9];
    if (map_we) begin
      kn[map_addr] = 1'b0;
      map_m[map_addr] = map_code;
    end
    key_m = kn;
    prev_tog_m = ps2_key[10];
    armed_m = 1;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk_sys);
    #1;
    if (chk_btn) check("btn_model", btn_out, btn_m);
    check("coin_model", {7'd0, coin_out}, {7'd0, coin_m});
  endtask

  task automatic ps2_event(input logic [8:0] code, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  task automatic map_write(input logic [2:0] a, input logic [8:0] c);
    map_we = 1'b1; map_addr = a; map_code = c;
  endtask

  logic [8:0] codes [10];
  int highs;

  initial begin
    codes = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h014, 9'h029, 9'h005, 9'h006, 9'h01A, 9'h000};
    reset_n = 1'b0; ps2_key = 11'h775; joy_in = '0; rotate = 2'd0;
    map_we = 1'b0; map_addr = '0; map_code = '0; af_mask = '0; chk_btn = 1;
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_btn", btn_out, 8'h00);
    check("reset_coin", {7'd0, coin_out}, 8'h00);
    reset_n = 1'b1;

    // toggle bit already high at release: no event may fire
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("no_event_btn", btn_out, 8'h00);
    end

    ps2_event(9'h175, 1'b1);
    cyc(); check("up_lat1", {7'd0, btn_out[0]}, 8'd0);
    cyc(); check("up_lat2", {7'd0, btn_out[0]}, 8'd1);
    ps2_event(9'h175, 1'b0);
    cyc(); check("up_rel1", {7'd0, btn_out[0]}, 8'd1);
    cyc(); check("up_rel2", {7'd0, btn_out[0]}, 8'd0);

    rotate = 2'd1; joy_in = 8'h04;
    cyc(); check("rot90", {4'd0, btn_out[3:0]}, 8'h01);
    rotate = 2'd2;
    cyc(); check("rot180", {4'd0, btn_out[3:0]}, 8'h08);
    rotate = 2'd3;
    cyc(); check("rot270", {4'd0, btn_out[3:0]}, 8'h02);
    rotate = 2'd0; joy_in = '0;
    cyc();

    ps2_event(9'h014, 1'b1);
    cyc(); cyc(); check("fire_on", {7'd0, btn_out[4]}, 8'd1);
    map_write(3'd4, 9'h01A);
    cyc(); map_we = 1'b0;
    cyc(); check("remap_clears", {7'd0, btn_out[4]}, 8'd0);
    ps2_event(9'h014, 1'b1);
    cyc(); cyc(); check("old_code_dead", {7'd0, btn_out[4]}, 8'd0);
    ps2_event(9'h01A, 1'b1);
    cyc(); cyc(); check("new_code_on", {7'd0, btn_out[4]}, 8'd1);
    ps2_event(9'h01A, 1'b0);
    cyc(); cyc(); check("new_code_off", {7'd0, btn_out[4]}, 8'd0);
    ps2_event(9'h01A, 1'b1); map_write(3'd4, 9'h029);
    cyc(); map_we = 1'b0;
    cyc(); check("write_wins", {7'd0, btn_out[4]}, 8'd0);
    ps2_event(9'h029, 1'b1);
    cyc(); cyc(); check("multi_match", {6'd0, btn_out[5:4]}, 8'h03);
    ps2_event(9'h029, 1'b0); map_write(3'd4, 9'h014);
    cyc(); map_we = 1'b0;
    cyc(); cyc(); check("multi_release", {6'd0, btn_out[5:4]}, 8'h00);

`ifdef AUTOFIRE_EN
    af_mask = 8'h10; chk_btn = 0;
    ps2_event(9'h014, 1'b1);
    cyc(); check("af_lat1", {7'd0, btn_out[4]}, 8'd0);
    for (int k = 0; k < 20; k++) begin
      cyc();
      check("af_pattern", {7'd0, btn_out[4]}, {7'd0, ((k / AD) % 2) == 0});
    end
    af_mask = '0; chk_btn = 1;
    ps2_event(9'h014, 1'b0);
    cyc(); cyc(); cyc();
`endif

    joy_in[6] = 1'b1; highs = 0;
    for (int i = 0; i < 40; i++) begin cyc(); highs += int'(coin_out); end
    check("coin_len1", 8'(highs), 8'(CP));
    joy_in[6] = 1'b0;
    repeat (3) cyc();
    joy_in[7] = 1'b1; highs = 0;
    for (int i = 0; i < 25; i++) begin cyc(); highs += int'(coin_out); end
    check("coin_len2", 8'(highs), 8'(CP));
    joy_in[7] = 1'b0;
    repeat (3) cyc();
    joy_in[6] = 1'b1;
    repeat (5) cyc();
    check("coin_mid_pulse", {7'd0, coin_out}, 8'd1);
    #2 reset_n = 1'b0;
    #1 check("coin_async_rst", {7'd0, coin_out}, 8'd0);
    joy_in = '0;
    model_reset();
    @(posedge clk_sys); @(posedge clk_sys); #1;
    reset_n = 1'b1;
    cyc();

    for (int i = 0; i < 400; i++) begin
      joy_in[5:0] = 6'($urandom);
      if ($urandom_range(0, 19) == 0) joy_in[7:6] = 2'($urandom);
      if ($urandom_range(0, 7) == 0) rotate = 2'($urandom);
      if ($urandom_range(0, 2) == 0) ps2_event(codes[$urandom_range(0, 9)], 1'($urandom));
      if ($urandom_range(0, 24) == 0) map_write(3'($urandom), codes[$urandom_range(0, 9)]);
      cyc();
      map_we = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_input_mapper.md
Name: ps2_input_mapper

Overview:
Parametrised input front-end for arcade cores. It turns hps_io PS/2 key events and joystick bits into a per-core button vector. The key map is programmable at run time, and the block provides selectable 0/90/180/270 direction rotation and a fixed-width coin pulse derived from the start buttons. It sits between hps_io and the core top, replacing the hard-coded per-core keyboard decode and orientation muxing.

Parameters:
NUM_BTN, 8, number of button slots (minimum 8); bits 0-3 are up/down/left/right.
COIN_PULSE, 600000, coin_out high time in clk_sys cycles (50 ms at 12 MHz).
AF_DIV, 200000, autofire half-period in cycles (used only with AUTOFIRE_EN).

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ps2_key  in  11  [7:0] scancode, [8] extended, [9] pressed, [10] toggles once per event
joy_in  in  NUM_BTN  joystick buttons, active high, same slot order as btn_out
rotate  in  2  0 none, 1 rot90, 2 rot180, 3 rot270
map_we  in  1  keymap write strobe
map_addr  in  $clog2(NUM_BTN)  slot to write
map_code  in  9  {extended, scancode}; 9'h000 disables the slot
btn_out  out  NUM_BTN  mapped, rotated buttons, active high
coin_out  out  1  coin pulse

Behaviour:
- Clock and reset: one clock domain, clk_sys. Reset is asynchronous and active-low (reset_n).
- Reset values:
  - btn_out=0, coin_out=0, key_state=0, armed=0.
  - Keymap slots 0-7 = 175,172,16B,174,014,029,005,006 (up, down, left, right, fire, fire2, start1, start2). Slots 8 and up = 000.
- Event detect:
  - prev_tog register. The first cycle after reset loads prev_tog from ps2_key[10] and sets armed; no event is generated on that cycle.
  - While armed, an event occurs in any cycle where ps2_key[10] != prev_tog.
- Key update:
  - On an event, every slot whose code equals {ps2_key[8],ps2_key[7:0]} and is nonzero sets key_state[slot] <= ps2_key[9].
  - Multiple matching slots all update. No match means no change.
- Keymap write:
  - map_we writes map_code into slot map_addr and clears key_state[map_addr], so no key can be left stuck.
  - An event in the same cycle compares against the old codes. The write wins for key_state of that slot.
  - map_addr >= NUM_BTN is ignored.
- Merge: raw = key_state | joy_in.
- Rotation (bits 0-3 only; other bits pass through):
  - rot90: up=left, down=right, left=down, right=up.
  - rot180: up=down, down=up, left=right, right=left.
  - rot270: up=right, down=left, left=up, right=down.
  - rotate is sampled every cycle; a change takes effect on the next btn_out update.
- Latency:
  - btn_out is registered. joy_in to btn_out: 1 cycle.
  - PS/2 toggle edge to btn_out: 2 cycles (key_state register, then btn_out register).
- Coin FSM (inputs are the post-mapping start bits, slots 6 and 7):
  - IDLE: on a rising edge of (start1|start2), coin_out<=1, load counter with COIN_PULSE-1, go to PULSE.
  - PULSE: decrement the counter. At 0, coin_out<=0 and go to HOLD.
  - HOLD: return to IDLE when start1|start2 is 0. A new press during PULSE or HOLD never retriggers.
  - Counter width is $clog2(COIN_PULSE+1).
  - Reset during PULSE forces coin_out=0 and state IDLE immediately.

Optional Feature:
AUTOFIRE_EN:
- Defined:
  - Adds input af_mask [NUM_BTN-1:0] and a free-running divider of AF_DIV cycles that toggles a phase bit.
  - For a masked slot that is pressed, the output equals the phase bit.
  - The rising edge of a masked press resets the divider and sets phase=1, so the first output cycle is high.
  - Autofire is applied after rotation.
- Undefined: the af_mask port does not exist, no divider logic is built, and AF_DIV is unused.

Test Plan:
1. Reset release with ps2_key[10]=1 held -> no event is generated; btn_out=0 for 10 cycles.
2. Event {tog flip, pressed=1, ext=1, code 75} -> btn_out[0]=1 exactly 2 cycles after the toggle edge. Release event -> btn_out[0]=0 after 2 cycles.
3. rotate=1, joy_in=4'b0100 (left) -> btn_out[3:0]=4'b0001 (up) after 1 cycle. Sweep rotate=2 -> 4'b1000; rotate=3 -> 4'b0010.
4. map_we slot 4 code 9'h01A while F pressed, then Z event -> old code 014 no longer sets bit 4, Z sets bit 4, key_state[4] cleared on the write cycle.
5. COIN_PULSE=16: start1 held for 40 cycles -> coin_out high for exactly 16 cycles, no retrigger. Release then press start2 -> a second 16-cycle pulse. Reset at cycle 5 of a pulse -> coin_out=0 immediately.
6. AUTOFIRE_EN, AF_DIV=4, af_mask[4]=1, fire held for 20 cycles -> btn_out[4] pattern 1111 0000 repeating, starting high 2 cycles after the press edge.
